// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants: PC step, the queue entry layout and the default reset PC.
package cpu_pkg;

  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched entries. Flush empties it in one cycle; storage is cleared only by reset.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign head_o  = mem[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own; count carries the extra bit.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr_q] <= push_data_i;
        wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// IF stage: owns the PC, issues in-order imem reads and queues responses toward IF/ID.
// Optional same-cycle bypass of an empty queue when FETCHQ_BYPASS_EN is defined.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       imem_req_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic                       imem_valid_i,
  input  logic [INST_W-1:0]          imem_instr_i,
  output logic                       id_valid_o,
  output logic [INST_W-1:0]          id_instr_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [ADDR_W-1:0]          id_pc4_o,
  input  logic                       id_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W+1:0]  in_use;
  logic              fifo_empty;
  entry_t            head;
  entry_t            resp_entry;
  logic              issue;
  logic              resp_live;
  logic              bypass_fire;
  logic              push;
  logic              pop;

  // Credits: queued + in flight + still-to-drop never exceeds DEPTH, so a push can never hit a full queue.
  assign in_use = {2'b00, fifo_count} + {2'b00, outstanding_q} + {2'b00, drop_q};
  assign issue  = rst_n_i && !redirect_i && (in_use < (CNT_W+2)'(DEPTH));

  // The oldest live request sits outstanding_q steps behind pc_q; drops always precede live responses.
  assign resp_live        = imem_valid_i && (drop_q == '0);
  assign resp_entry.pc    = pc_q - ADDR_W'(outstanding_q) * ADDR_W'(PC_STEP);
  assign resp_entry.instr = imem_instr_i;

`ifdef FETCHQ_BYPASS_EN
  assign bypass_fire = fifo_empty && resp_live && !redirect_i;
`else
  assign bypass_fire = 1'b0;
`endif

  // Handshake: an entry transfers to decode on a cycle where id_valid_o && id_ready_i and no redirect;
  // id_* hold steady while id_valid_o is high and id_ready_i is low.
  assign push = resp_live && !redirect_i && !(bypass_fire && id_ready_i);
  assign pop  = !fifo_empty && id_ready_i && !redirect_i;

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign id_valid_o  = !fifo_empty || bypass_fire;
  assign id_instr_o  = bypass_fire ? imem_instr_i : head.instr;
  assign id_pc_o     = bypass_fire ? resp_entry.pc : head.pc;
  assign id_pc4_o    = id_pc_o + ADDR_W'(PC_STEP);
  assign count_o     = fifo_count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else if (redirect_i) begin
      // Everything in flight becomes a drop; a response landing this cycle is already one of them.
      pc_q          <= redirect_pc_i;
      outstanding_q <= '0;
      drop_q        <= drop_q + outstanding_q - CNT_W'(imem_valid_i);
    end else begin
      if (issue) pc_q <= pc_q + ADDR_W'(PC_STEP);
      if (imem_valid_i && (drop_q != '0)) drop_q <= drop_q - CNT_W'(1);
      outstanding_q <= outstanding_q + CNT_W'(issue) - CNT_W'(resp_live);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (resp_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: scripted phases drive a latency-configurable memory model; a monitor
// checks every decode handshake against the expected PC queue. A second instance covers PC wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n, redirect, imem_req, imem_valid, id_valid, id_ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, id_instr, id_pc, id_pc4;
  logic [2:0]  count;

  logic        w_rst_n, w_req, w_valid, w_id_valid;
  logic [31:0] w_addr, w_instr, w_id_instr, w_id_pc, w_id_pc4;
  logic [2:0]  w_count;

  int unsigned cyc = 0;
  int          lat = 1;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_req = 0;
  int          n_hs  = 0;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } pend_t;
  pend_t       pend_q[$];
  logic [31:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_queue u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_valid_i(imem_valid),
    .imem_instr_i(imem_instr), .id_valid_o(id_valid), .id_instr_o(id_instr),
    .id_pc_o(id_pc), .id_pc4_o(id_pc4), .id_ready_i(id_ready), .count_o(count)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk), .rst_n_i(w_rst_n), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_valid_i(w_valid),
    .imem_instr_i(w_instr), .id_valid_o(w_id_valid), .id_instr_o(w_id_instr),
    .id_pc_o(w_id_pc), .id_pc4_o(w_id_pc4), .id_ready_i(1'b1), .count_o(w_count)
  );

  function automatic logic [31:0] mem_instr(input logic [31:0] a);
    return 32'h2002_000A ^ {a[23:0], 8'h00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Memory model and scoreboard monitor
  always @(negedge clk) begin
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_instr = mem_instr(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_valid = 1'b0;
      imem_instr = 32'h0;
    end
    #1;
    if (!rst_n) begin
      pend_q.delete();
    end else begin
      if (imem_req) begin
        pend_q.push_back('{due: cyc + lat, addr: imem_addr});
        n_req++;
      end
      if (id_valid && id_ready && !redirect) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          check("hs_unexpected", {32'h0, id_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("hs_pc", {32'h0, id_pc}, {32'h0, e});
          check("hs_instr", {32'h0, id_instr}, {32'h0, mem_instr(e)});
          check("hs_pc4", {32'h0, id_pc4}, {32'h0, e + 32'd4});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w_prev_addr, w_exp_pc;
    logic        w_prev_req;
    int          hs0;

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    w_rst_n = 1'b0; w_valid = 1'b0; w_instr = '0;

    // Phase 1: reset state, streaming with L=1
    lat = 1;
    tick(3);
    #1;
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_valid", {63'h0, id_valid}, 64'h0);
    check("rst_count", {61'h0, count}, 64'h0);
    check("rst_pc", {32'h0, id_pc}, 64'h0);
    check("rst_instr", {32'h0, id_instr}, 64'h0);
    exp_q.delete(); push_exp(32'h0, 16); n_hs = 0;
    tick(1); rst_n = 1'b1; #1;
    check("p1_req0", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    tick(1); #1;
    check("p1_addr1", {32'h0, imem_addr}, 64'h4);
`ifdef FETCHQ_BYPASS_EN
    check("byp_valid", {63'h0, id_valid}, 64'h1);
    check("byp_instr", {32'h0, id_instr}, 64'h2002_000A);
    check("byp_count", {61'h0, count}, 64'h0);
`else
    check("p1_valid_t1", {63'h0, id_valid}, 64'h0);
    tick(1); #1;
    check("p1_valid_t2", {63'h0, id_valid}, 64'h1);
    check("p1_pc4_t2", {32'h0, id_pc4}, 64'h4);
`endif
    tick(10);
    check("p1_stream", {63'h0, n_hs >= 8}, 64'h1);

    // Phase 2: decode stalled from reset, queue fills to DEPTH
    tick(1); rst_n = 1'b0; id_ready = 1'b0;
    tick(2); exp_q.delete(); n_req = 0; n_hs = 0;
    tick(1); rst_n = 1'b1;
    tick(10); #1;
    check("p2_nreq", 64'(n_req), 64'd4);
    check("p2_count", {61'h0, count}, 64'd4);
    check("p2_req", {63'h0, imem_req}, 64'h0);
    check("p2_head_pc", {32'h0, id_pc}, 64'h0);
    check("p2_head_instr", {32'h0, id_instr}, {32'h0, mem_instr(32'h0)});
    push_exp(32'h0, 16);
    tick(1); id_ready = 1'b1;
    tick(10);
    check("p2_drain", {63'h0, n_hs >= 6}, 64'h1);

    // Phase 3: L=3, redirect with two requests in flight
    tick(1); rst_n = 1'b0; id_ready = 1'b0; lat = 3;
    tick(2); exp_q.delete(); n_hs = 0;
    tick(1); rst_n = 1'b1;
    tick(2); redirect = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
    push_exp(32'h100, 16); #1;
    check("p3_req_redir", {63'h0, imem_req}, 64'h0);
    tick(1); redirect = 1'b0; #1;
    check("p3_first_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h100});
    check("p3_valid", {63'h0, id_valid}, 64'h0);
    tick(15);
    check("p3_stream", {63'h0, n_hs >= 4}, 64'h1);

    // Phase 4: full queue, redirect and ready in the same cycle
    id_ready = 1'b0;
    tick(12); #1;
    check("p4_full", {61'h0, count}, 64'd4);
    tick(1); redirect = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1;
    exp_q.delete(); push_exp(32'h200, 16); hs0 = n_hs;
    tick(1); redirect = 1'b0; #1;
    check("p4_valid", {63'h0, id_valid}, 64'h0);
    check("p4_count", {61'h0, count}, 64'h0);
    tick(12);
    check("p4_stream", {63'h0, (n_hs - hs0) >= 4}, 64'h1);

    // Phase 5: reset PC near the top of the address space wraps through zero
    tick(1); rst_n = 1'b0;
    tick(2); w_rst_n = 1'b1;
    w_prev_req = 1'b0; w_prev_addr = '0; w_exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 8; i++) begin
      w_valid = w_prev_req;
      w_instr = mem_instr(w_prev_addr);
      #1;
      check("wrap_addr", {31'h0, w_req, w_addr}, {31'h0, 1'b1, 32'hFFFF_FFF8 + 32'(4 * i)});
      if (w_id_valid) begin
        check("wrap_hs_pc", {32'h0, w_id_pc}, {32'h0, w_exp_pc});
        check("wrap_hs_pc4", {32'h0, w_id_pc4}, {32'h0, w_exp_pc + 32'd4});
        check("wrap_hs_instr", {32'h0, w_id_instr}, {32'h0, mem_instr(w_exp_pc)});
        w_exp_pc = w_exp_pc + 32'd4;
      end
      w_prev_req  = w_req;
      w_prev_addr = w_addr;
      tick(1);
    end
    w_valid = 1'b0;
    check("wrap_hs_total", {32'h0, w_exp_pc}, 64'h0000_0010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
